// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between instruction fetch and
// the MEM-stage data port. Data has priority; IF is forced through after a bounded DM streak.
module mem_port_arbiter #(
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        StallF,
    output logic        StallM,
    output logic        bus_err
);

    localparam int          STREAK_W = $clog2(MAX_DM_STREAK + 1);
    localparam int          TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_DM,
        SERVE_IF,
        DONE_DM,
        DONE_IF
    } state_t;

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    logic        mem_req_d, mem_we_d;
    logic [31:0] mem_addr_d, mem_wdata_d;
    logic        if_done_d, dm_done_d;
    logic [31:0] if_rdata_d, dm_rdata_d;
    logic        bus_err_d;

    logic dm_pend;
    logic if_forced;
    logic tmo_hit;

    assign dm_pend   = dm_read | dm_write;
    assign if_forced = if_req && (streak_q == STREAK_W'(MAX_DM_STREAK));
    assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT - 1));

    // Stalls must react in the same cycle the request appears, so they bypass the registers.
    assign StallM = dm_pend & (state_q != DONE_DM);
    assign StallF = StallM | (if_req & (state_q != DONE_IF));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d     = state_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        if_rdata_d  = if_rdata;
        dm_rdata_d  = dm_rdata;
        bus_err_d   = bus_err;

        unique case (state_q)
            IDLE: begin
                if (dm_pend && !if_forced) begin
                    state_d     = SERVE_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_write;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    tmo_d       = '0;
                    if (!if_req)
                        streak_d = '0;
                    else if (streak_q != STREAK_W'(MAX_DM_STREAK))
                        streak_d = streak_q + 1'b1;
                end else if (if_req) begin
                    state_d    = SERVE_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    tmo_d      = '0;
                    streak_d   = '0;
                end
            end

            SERVE_DM: begin
                if (mem_ready) begin
                    state_d   = DONE_DM;
                    mem_req_d = 1'b0;
                    dm_done_d = 1'b1;
                    if (!mem_we)
                        dm_rdata_d = mem_rdata;
                end else if (tmo_hit) begin
                    state_d    = DONE_DM;
                    mem_req_d  = 1'b0;
                    dm_done_d  = 1'b1;
                    dm_rdata_d = ERR_WORD;
                    bus_err_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            SERVE_IF: begin
                if (mem_ready) begin
                    state_d    = DONE_IF;
                    mem_req_d  = 1'b0;
                    if_done_d  = 1'b1;
                    if_rdata_d = mem_rdata;
                end else if (tmo_hit) begin
                    state_d    = DONE_IF;
                    mem_req_d  = 1'b0;
                    if_done_d  = 1'b1;
                    if_rdata_d = ERR_WORD;
                    bus_err_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            // The pipeline advances at the end of DONE, so no grant is made here.
            DONE_DM, DONE_IF: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            tmo_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            bus_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            streak_q  <= streak_d;
            tmo_q     <= tmo_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_done   <= if_done_d;
            dm_done   <= dm_done_d;
            if_rdata  <= if_rdata_d;
            dm_rdata  <= dm_rdata_d;
            bus_err   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small latency-programmable memory model answers
// requests, and each task checks one scenario against hand-derived expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_read = 1'b0;
    logic        dm_write = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        StallF;
    logic        StallM;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    int   mem_lat = 1;
    int   mem_cyc = 0;
    logic force_ready = 1'b0;

    mem_port_arbiter #(.MAX_DM_STREAK(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .StallF(StallF), .StallM(StallM), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'h12345678 : ~a;
    endfunction

    // Memory model: ready in the mem_lat-th cycle of a request; mem_lat==0 never answers.
    always @(negedge clk) begin
        if (mem_req && mem_lat != 0) begin
            mem_cyc   = mem_cyc + 1;
            mem_ready = force_ready || (mem_cyc >= mem_lat);
        end else begin
            mem_cyc   = 0;
            mem_ready = force_ready;
        end
        mem_rdata = mem_word(mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input bit is_dm, input int budget, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < budget) begin
            tick();
            cycles++;
            seen = is_dm ? dm_done : if_done;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, if_done, dm_done, if_rdata, dm_rdata, bus_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h done=%b/%b err=%b expected all 0",
                     mem_req, mem_we, mem_addr, if_done, dm_done, bus_err);
        end
        checks++;
        if ({StallF, StallM} !== 2'b00) begin
            errors++;
            $display("FAIL reset_stalls: got %b%b expected 00", StallF, StallM);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        int  cyc;
        bit  seen;
        mem_lat = 2;
        dm_read = 1'b1;
        dm_addr = 32'h100;
        #1;
        checks++;
        if (StallM !== 1'b1) begin
            errors++;
            $display("FAIL load_stall_idle: got %b expected 1", StallM);
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            seen = dm_done;
            if (!seen) begin
                checks++;
                if ({mem_req, mem_we, mem_addr, StallM} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin
                    errors++;
                    $display("FAIL load_serve: got req=%b we=%b addr=%h stallm=%b expected 1 0 00000100 1",
                             mem_req, mem_we, mem_addr, StallM);
                end
            end
        end
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL load_latency: got %0d cycles expected 3", cyc);
        end
        checks++;
        if ({dm_rdata, StallM, mem_req} !== {32'h12345678, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_done: got rdata=%h stallm=%b req=%b expected 12345678 0 0",
                     dm_rdata, StallM, mem_req);
        end
        dm_read = 1'b0;
        tick();
        checks++;
        if (dm_done !== 1'b0) begin
            errors++;
            $display("FAIL load_pulse_width: got %b expected 0", dm_done);
        end
    endtask

    task automatic test_collision();
        mem_lat  = 1;
        dm_write = 1'b1;
        dm_addr  = 32'h40;
        dm_wdata = 32'hA5A5A5A5;
        if_req   = 1'b1;
        if_addr  = 32'h0;
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, StallF} !== {1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b1}) begin
            errors++;
            $display("FAIL coll_store_grant: got req=%b we=%b addr=%h wdata=%h stallf=%b expected 1 1 00000040 a5a5a5a5 1",
                     mem_req, mem_we, mem_addr, mem_wdata, StallF);
        end
        tick();
        checks++;
        if ({dm_done, mem_req, dm_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
            errors++;
            $display("FAIL coll_store_done: got done=%b req=%b rdata=%h expected 1 0 12345678",
                     dm_done, mem_req, dm_rdata);
        end
        dm_write = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL coll_idle_gap: got req=%b expected 0", mem_req);
        end
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL coll_fetch_grant: got req=%b we=%b addr=%h expected 1 0 00000000",
                     mem_req, mem_we, mem_addr);
        end
        tick();
        checks++;
        if ({if_done, mem_req, if_rdata, StallF} !== {1'b1, 1'b0, 32'hFFFFFFFF, 1'b0}) begin
            errors++;
            $display("FAIL coll_fetch_done: got done=%b req=%b rdata=%h stallf=%b expected 1 0 ffffffff 0",
                     if_done, mem_req, if_rdata, StallF);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        logic [31:0] grants[$];
        logic [31:0] exp_seq[6];
        logic        prev_req;
        int          cyc;
        exp_seq = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h80, 32'h200};
        mem_lat  = 1;
        dm_read  = 1'b1;
        dm_addr  = 32'h200;
        if_req   = 1'b1;
        if_addr  = 32'h80;
        prev_req = mem_req;
        cyc      = 0;
        while (grants.size() < 6 && cyc < 60) begin
            tick();
            cyc++;
            if (mem_req && !prev_req)
                grants.push_back(mem_addr);
            if ((if_done || dm_done) && mem_req) begin
                checks++;
                errors++;
                $display("FAIL starve_req_in_done: got req=1 expected 0");
            end
            prev_req = mem_req;
        end
        checks++;
        if (grants.size() !== 6) begin
            errors++;
            $display("FAIL starve_grant_count: got %0d expected 6", grants.size());
        end
        for (int i = 0; i < grants.size(); i++) begin
            checks++;
            if (grants[i] !== exp_seq[i]) begin
                errors++;
                $display("FAIL starve_grant_%0d: got %h expected %h", i, grants[i], exp_seq[i]);
            end
        end
        dm_read = 1'b0;
        if_req  = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        int cyc;
        bit seen;
        mem_lat = 0;
        if_req  = 1'b1;
        if_addr = 32'h300;
        wait_done(1'b0, 300, cyc, seen);
        checks++;
        if (!seen || cyc !== 256) begin
            errors++;
            $display("FAIL tmo_latency: got seen=%b after %0d cycles expected 1 after 256", seen, cyc);
        end
        checks++;
        if ({if_rdata, bus_err, mem_req} !== {32'hDEADBEEF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL tmo_result: got rdata=%h err=%b req=%b expected deadbeef 1 0",
                     if_rdata, bus_err, mem_req);
        end
        if_req  = 1'b0;
        tick();
        mem_lat = 1;
        dm_read = 1'b1;
        dm_addr = 32'h100;
        wait_done(1'b1, 20, cyc, seen);
        checks++;
        if ({seen, dm_rdata, bus_err} !== {1'b1, 32'h12345678, 1'b1}) begin
            errors++;
            $display("FAIL tmo_sticky: got seen=%b rdata=%h err=%b expected 1 12345678 1",
                     seen, dm_rdata, bus_err);
        end
        dm_read = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        mem_lat = 3;
        dm_read = 1'b1;
        dm_addr = 32'h100;
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_serve: got req=%b expected 1", mem_req);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({mem_req, dm_done, bus_err} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_edge: got req=%b done=%b err=%b expected 0 0 0",
                     mem_req, dm_done, bus_err);
        end
        rst_n       = 1'b1;
        dm_read     = 1'b0;
        force_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({mem_req, dm_done, if_done, dm_rdata} !== {3'b000, 32'h0}) begin
            errors++;
            $display("FAIL rst_late_ready: got req=%b done=%b/%b rdata=%h expected 0 0/0 00000000",
                     mem_req, dm_done, if_done, dm_rdata);
        end
        force_ready = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit seen;
        mem_lat = 1;
        if_req  = 1'b1;
        if_addr = 32'h1000;
        for (int k = 0; k < 4; k++) begin
            wait_done(1'b0, 20, cyc, seen);
            checks++;
            if ({seen, if_rdata} !== {1'b1, ~(32'h1000 + 32'(4 * k))}) begin
                errors++;
                $display("FAIL b2b_data_%0d: got seen=%b rdata=%h expected 1 %h",
                         k, seen, if_rdata, ~(32'h1000 + 32'(4 * k)));
            end
            if (k > 0) begin
                checks++;
                if (cyc !== 3) begin
                    errors++;
                    $display("FAIL b2b_period_%0d: got %0d cycles expected 3", k, cyc);
                end
            end
            if_addr = if_addr + 32'd4;
        end
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_collision();
        test_starvation();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
